// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the register-file write-back queue: default widths,
// the queue-entry layout and a small sizing helper.
package wb_write_queue_pkg;

  localparam int WBQ_DATA_W = 32;
  localparam int WBQ_ADDR_W = 5;
  localparam int WBQ_DEPTH  = 4;

  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] reg_idx;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int wbq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bundle of the write-request, register-file write and bypass signals.
// The queue side is the slave; producers and the decode stage form the master.
interface wb_write_queue_if
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W,
  parameter int DEPTH  = WBQ_DEPTH
);

  localparam int CNT_W = wbq_cnt_w(DEPTH);

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              in_ready;

  logic [ADDR_W-1:0] Write_Reg;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;

  logic [ADDR_W-1:0] Read_Reg1;
  logic [ADDR_W-1:0] Read_Reg2;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;

  logic [CNT_W-1:0]  count;

  modport slave (
    input  mem_valid, mem_reg, mem_data,
    input  alu_valid, alu_reg, alu_data,
    input  Read_Reg1, Read_Reg2,
    output in_ready,
    output Write_Reg, Write_Data, RegWrite,
    output byp_hit1, byp_data1, byp_hit2, byp_data2,
    output count
  );

  modport master (
    output mem_valid, mem_reg, mem_data,
    output alu_valid, alu_reg, alu_data,
    output Read_Reg1, Read_Reg2,
    input  in_ready,
    input  Write_Reg, Write_Data, RegWrite,
    input  byp_hit1, byp_data1, byp_hit2, byp_data2,
    input  count
  );

endinterface

// File: rtl/wbq_fifo.sv
// Pending-write storage: two write ports (port 0 is older), one read port,
// wrapping pointers and an occupancy count. All slots are exposed for bypass.
module wbq_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int  DEPTH   = WBQ_DEPTH,
  parameter type entry_t = wbq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_en_i,
  input  entry_t                   wr0_i,
  input  logic                     wr1_en_i,
  input  entry_t                   wr1_i,
  input  logic                     rd_en_i,
  output entry_t                   rd_o,
  output entry_t [DEPTH-1:0]       mem_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         n_push;
  logic               pop;
  entry_t             first;

  // A lone port-1 write lands in the first free slot, keeping the FIFO dense.
  always_comb begin
    n_push   = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
    first    = wr0_en_i ? wr0_i : wr1_i;
    pop      = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; a slot is only meaningful while the pointers
  // mark it occupied, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      mem_q[wr_ptr_q] <= first;
    end
    if (n_push == 2'd2) begin
      mem_q[wr_ptr_q + PTR_W'(1)] <= wr1_i;
    end
  end

  assign rd_o     = mem_q[rd_ptr_q];
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: merges load and ALU results into one register-file write
// port, one write per cycle, with a bypass view of every not-yet-retired write.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W,
  parameter int DEPTH  = WBQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_write_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = wbq_cnt_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic               in_ready;
  logic               mem_acc, alu_acc;
  entry_t             mem_entry, alu_entry;
  entry_t             head;
  entry_t [DEPTH-1:0] slots;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               pop;

  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;

  logic               byp_hit1, byp_hit2;
  logic [DATA_W-1:0]  byp_data1, byp_data2;

  // Two free slots are required so a dual push can never overflow.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));

  // Writes to register 0 are accepted but never stored.
  assign mem_acc   = bus.mem_valid && in_ready && (bus.mem_reg != '0);
  assign alu_acc   = bus.alu_valid && in_ready && (bus.alu_reg != '0);
  assign mem_entry = '{reg_idx: bus.mem_reg, data: bus.mem_data};
  assign alu_entry = '{reg_idx: bus.alu_reg, data: bus.alu_data};
  assign pop       = (count != '0);

  wbq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en_i (mem_acc),
    .wr0_i    (mem_entry),
    .wr1_en_i (alu_acc),
    .wr1_i    (alu_entry),
    .rd_en_i  (pop),
    .rd_o     (head),
    .mem_o    (slots),
    .rd_ptr_o (rd_ptr),
    .count_o  (count)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = head.reg_idx;
      write_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Age order is: write port (oldest), then queue head to tail. Scanning in
  // that order and letting later matches override yields the youngest value.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] idx);
    logic             hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0] slot;
    hit  = 1'b0;
    data = '0;
    slot = '0;
    if (idx != '0) begin
      if (reg_write_q && (write_reg_q == idx)) begin
        hit  = 1'b1;
        data = write_data_q;
      end
      for (int age = 0; age < DEPTH; age++) begin
        slot = rd_ptr + PTR_W'(age);
        if ((CNT_W'(age) < count) && (slots[slot].reg_idx == idx)) begin
          hit  = 1'b1;
          data = slots[slot].data;
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = lookup(bus.Read_Reg1);
    {byp_hit2, byp_data2} = lookup(bus.Read_Reg2);
  end

  assign bus.in_ready   = in_ready;
  assign bus.count      = count;
  assign bus.RegWrite   = reg_write_q;
  assign bus.Write_Reg  = write_reg_q;
  assign bus.Write_Data = write_data_q;
  assign bus.byp_hit1   = byp_hit1;
  assign bus.byp_data1  = byp_data1;
  assign bus.byp_hit2   = byp_hit2;
  assign bus.byp_data2  = byp_data2;

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 4, pending-write queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_valid / mem_reg / mem_data  input  1 / ADDR_W / DATA_W  load-result write request.
REQ-007 alu_valid / alu_reg / alu_data  input  1 / ADDR_W / DATA_W  ALU-result write request.
REQ-008 in_ready  output  1  queue can accept two requests this cycle.
REQ-009 Write_Reg / Write_Data / RegWrite  output  ADDR_W / DATA_W / 1  register-file write port, all registered.
REQ-010 Read_Reg1 / Read_Reg2  input  ADDR_W each  decode-stage read indices for bypass lookup.
REQ-011 byp_hit1 / byp_data1, byp_hit2 / byp_data2  output  1 / DATA_W each  combinational bypass result per read index.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Requests SHALL be accepted only when valid and in_ready are both high; otherwise dropped, and the producer is responsible for holding them.
REQ-014 in_ready SHALL be high when count <= DEPTH-2.
REQ-015 Requests with reg index 0 SHALL be accepted and discarded (no enqueue, no RegWrite).
REQ-016 Simultaneous mem and alu acceptance SHALL enqueue mem first (older), alu second, in the same cycle.
REQ-017 Queue SHALL be FIFO; head entry SHALL be written to the register file exactly once.
REQ-018 When non-empty, each cycle SHALL pop the head and drive RegWrite=1, Write_Reg/Write_Data = head on the next cycle (1-cycle latency); otherwise RegWrite=0.
REQ-019 Simultaneous push and pop SHALL be permitted; count SHALL update by pushes minus pop.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH.
REQ-021 byp_hitN SHALL be 1 when Read_RegN != 0 matches any queued entry or the entry currently on the Write_Reg port with RegWrite=1; byp_dataN SHALL come from the youngest match.
REQ-022 Read_RegN = 0 SHALL give byp_hitN=0, byp_dataN=0.
REQ-023 Same-cycle incoming requests SHALL NOT be visible to bypass until enqueued.
REQ-024 count SHALL never exceed DEPTH; overflow is impossible by REQ-014.

Reset
REQ-025 rst_n low SHALL immediately clear pointers, count, RegWrite, Write_Reg, Write_Data to 0; in_ready SHALL be 1.
REQ-026 Reset mid-operation SHALL discard all pending writes; none SHALL reach the register file.
REQ-027 First acceptance SHALL occur on the first clk edge after rst_n deasserts.

Structure
REQ-028 Shared package SHALL hold DATA_W, ADDR_W defaults and the queue-entry struct (reg index, data).
REQ-029 Queue storage plus pointers SHALL be one sub-module, wbq_fifo (two write ports, one read port); bypass match logic SHALL stay in the top.

Verification
REQ-030 Single alu write reg 5 = 0xDEADBEEF -> next cycle RegWrite=1, Write_Reg=5, Write_Data=0xDEADBEEF; following cycle RegWrite=0.
REQ-031 Simultaneous mem reg 3=0x11 and alu reg 3=0x22 -> writes 0x11 then 0x22 on consecutive cycles; bypass for Read_Reg1=3 returns 0x22 while both are pending.
REQ-032 Continuous dual pushes every cycle -> in_ready falls when count reaches DEPTH-1; count never exceeds 4; all writes emerge in order.
REQ-033 alu write reg 0 = 0xFFFF -> no RegWrite, count stays 0, byp_hit for Read_Reg=0 stays 0.
REQ-034 Fill queue with 3 entries, pulse rst_n low -> RegWrite=0 immediately, count=0, no queued write ever issued.
REQ-035 Push past pointer wrap (10 sequential writes, regs 1..10) -> Write_Reg sequence 1..10 exactly, data intact.
